// File: rtl/trig_lut_sched.sv
// Scheduler for the shared cosine LUT: arbitrates two phase requesters onto
// the single read port, reads cos(theta) then cos(theta - quarter turn) = sin,
// and returns both words as one response.
//
// Handshakes: a transfer happens in a cycle where valid && ready are both
// high. Producers may raise valid at any time; ready never depends on the
// handshake it completes. rsp_* payload is held while rsp_valid is high.
module trig_lut_sched #(
   parameter int D_WIDTH = 16,
   parameter int LUT_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [D_WIDTH-1:0] req0_theta,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [D_WIDTH-1:0] req1_theta,
   output logic               lut_en,
   output logic [D_WIDTH-1:0] lut_addr,
   input  logic [D_WIDTH-1:0] lut_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [D_WIDTH-1:0] rsp_cos,
   output logic [D_WIDTH-1:0] rsp_sin,
   output logic [2:0]         dbg_state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_COS  = 3'd1;
   localparam logic [2:0] S_SIN  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   // A quarter turn in theta codes; sin(theta) = cos(theta - quarter).
   localparam logic [D_WIDTH-1:0] QUARTER = {2'b01, {(D_WIDTH-2){1'b0}}};

   logic [2:0]         state_q, state_d;
   logic               last_grant_q;
   logic               id_q;
   logic [D_WIDTH-1:0] addr_q;
   logic [D_WIDTH-1:0] cos_q;
   logic [D_WIDTH-1:0] sin_q;
   // One-hot delay lines marking the cycle each read's data is on lut_data.
   logic [LUT_LAT-1:0] cos_pipe_q, cos_pipe_d;
   logic [LUT_LAT-1:0] sin_pipe_q, sin_pipe_d;

   logic               grant;
   logic               idle;
   logic               hs;
   logic               cap_cos;
   logic               cap_sin;
   logic [D_WIDTH-1:0] theta_in;

   // Round-robin grant: a lone requester wins, contention goes to the one not served last.
   always_comb begin
      grant    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      idle     = rst_n && (state_q == S_IDLE);
      theta_in = grant ? req1_theta : req0_theta;
   end

   assign req0_ready = idle && req0_valid && !grant;
   assign req1_ready = idle && req1_valid && grant;
   assign hs         = req0_ready || req1_ready;
   assign cap_cos    = cos_pipe_q[LUT_LAT-1];
   assign cap_sin    = sin_pipe_q[LUT_LAT-1];

   // Advance the read-tracking delay lines by one cycle.
   always_comb begin
      cos_pipe_d = LUT_LAT'({cos_pipe_q, (state_q == S_COS)});
      sin_pipe_d = LUT_LAT'({sin_pipe_q, (state_q == S_SIN)});
   end

   // Request sequencing: accept, two reads, wait for sin data, then respond.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hs) state_d = S_COS;
         S_COS:   state_d = S_SIN;
         S_SIN:   state_d = S_WAIT;
         S_WAIT:  if (cap_sin) state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, arbitration history and read tracking; reset drops any in-flight work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         cos_pipe_q   <= '0;
         sin_pipe_q   <= '0;
      end else begin
         state_q    <= state_d;
         cos_pipe_q <= cos_pipe_d;
         sin_pipe_q <= sin_pipe_d;
         if (hs) begin
            id_q         <= grant;
            last_grant_q <= grant;
         end
      end
   end

   // LUT address: theta on accept (shown during the cos read), then theta - quarter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else if (hs) begin
         addr_q <= theta_in;
      end else if (state_q == S_COS) begin
         addr_q <= addr_q - QUARTER;
      end
   end

   // Capture LUT returns in the cycle each read's data is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cos_q <= '0;
         sin_q <= '0;
      end else begin
         if (cap_cos) cos_q <= lut_data;
         if (cap_sin) sin_q <= lut_data;
      end
   end

   assign lut_en    = (state_q == S_COS) || (state_q == S_SIN);
   assign lut_addr  = addr_q;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = id_q;
   assign rsp_cos   = cos_q;
   assign rsp_sin   = sin_q;
   assign dbg_state = state_q;

endmodule

// File: doc/trig_lut_sched.md
# trig_lut_sched

Request scheduler for the shared cosine lookup table in the trig datapath. Arbitrates two requesters onto the single LUT read port and issues two reads per request: cos(θ), then cos(θ − π/2) = sin(θ). Returns both results as one response with valid/ready handshaking. Sits between the phase-generating blocks and the LUT memory.

## Interface
- D_WIDTH, 16: width of theta, LUT address and LUT data; theta spans one full turn over 2^D_WIDTH codes.
- LUT_LAT, 1: LUT read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a theta
- req0_ready  out  1  requester 0 accepted this cycle when valid&&ready
- req0_theta  in  D_WIDTH  requester 0 phase
- req1_valid / req1_ready / req1_theta: same as the requester 0 ports, for requester 1
- lut_en  out  1  LUT read strobe
- lut_addr  out  D_WIDTH  LUT read address
- lut_data  in  D_WIDTH  LUT read data, valid LUT_LAT cycles after the cycle lut_en=1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_cos  out  D_WIDTH  LUT[theta]
- rsp_sin  out  D_WIDTH  LUT[(theta − 2^(D_WIDTH−2)) mod 2^D_WIDTH]

## Operation
- States: IDLE, ISSUE_COS, ISSUE_SIN, WAIT, RESP. One request in flight at a time.
- IDLE: the grant is combinational from the valids and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ last_grant is granted.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high in any cycle.
  - On a handshake: latch theta, latch id, last_grant ← id, go to ISSUE_COS.
- ISSUE_COS: lut_en=1, lut_addr=theta. Next state ISSUE_SIN.
- ISSUE_SIN: lut_en=1, lut_addr=theta − 2^(D_WIDTH−2). Subtraction is modulo 2^D_WIDTH (wraps, no saturation). Next state WAIT.
- WAIT: capture lut_data into the cos register LUT_LAT cycles after the ISSUE_COS cycle, and into the sin register LUT_LAT cycles after the ISSUE_SIN cycle. Leave WAIT after the sin capture.
- RESP: rsp_valid=1. rsp_id, rsp_cos and rsp_sin are held stable. On rsp_valid&&rsp_ready, go to IDLE.
- No new request is accepted while a request is in flight, including during RESP.
- lut_en=0 in all states except ISSUE_COS and ISSUE_SIN. lut_addr holds its last value when lut_en=0.
- LUT data is used unsigned/opaque. The block does no arithmetic on data.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - state=IDLE, last_grant=1 so req0 wins the first contention.
  - rsp_valid=0, rsp_id=0, rsp_cos=0, rsp_sin=0, lut_en=0, lut_addr=0.
  - req0_ready and req1_ready are 0 while rst_n=0.
- With the handshake in cycle T:
  - cos issued at T+1, sin issued at T+2.
  - sin data arrives at T+2+LUT_LAT.
  - rsp_valid rises at T+3+LUT_LAT. With LUT_LAT=1, that is T+4.
- If rsp_ready=1 in the first RESP cycle, IDLE is at T+4+LUT_LAT and the next handshake can occur in that cycle.
- Throughput: one request per 4+LUT_LAT cycles when there is no backpressure.
- Reset mid-operation: the in-flight request is discarded with no response. LUT returns that arrive after reset deassertion are ignored, because the state is IDLE and no capture is pending.
- rsp_ready asserted outside RESP has no effect.

## Test plan
- LUT model returns addr^0xA5A5, D_WIDTH=16, LUT_LAT=1. Single req0 with theta=0x0000 at cycle T:
  - lut_addr 0x0000 at T+1, 0xC000 at T+2.
  - rsp_valid at T+4 with rsp_cos=0xA5A5, rsp_sin=0x65A5, rsp_id=0.
- Wrap-around: req1 theta=0x1000 -> sin address 0xD000, rsp_sin=0x75A5, rsp_cos=0xB5A5, rsp_id=1.
- Contention: both valid continuously from reset release:
  - first grant is req0, then req1, then req0.
  - rsp_id sequence 0,1,0, and a ready is never high for both requesters.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid and payload stay stable, both readys stay 0.
  - Release rsp_ready -> IDLE the next cycle.
- LUT_LAT=3: handshake at T -> rsp_valid at T+6, with correct cos/sin values.
- Reset mid-operation: assert rst_n=0 in the ISSUE_SIN cycle.
  - All outputs return to reset values immediately.
  - After release, no response is produced for the aborted request.
  - A fresh req0 with theta=0x4000 yields rsp_cos=0xE5A5 and rsp_sin=0xA5A5.
